i2c_arbiter: RTL and testbench
==============================

# i2c_arbiter

Shares the single `i2c_dri` byte-transaction engine between two requesters: requester 0 is `e2prom_rw`, and requester 1 is a second on-board client such as a sensor or RTC poller. The block arbitrates round-robin and latches the winner's command. It issues one `i2c_exec` pulse, waits for `i2c_done` under a watchdog, and returns read data and status to the winner. It sits between the clients and `i2c_dri` and runs on the driver's `dri_clk`.

## Interface
- `TIMEOUT_CYC`, default 20000: max cycles waiting for `i2c_done` after `i2c_exec`. Range 2..65535.
- `GAP_CYC`, default 4: idle cycles forced between consecutive transactions. Range 0..255.
- `clk`, in, 1: the block's only clock. Connect to `dri_clk` of `i2c_dri`.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, 2: per-requester request level; bit r belongs to requester r.
- `req_bit_ctrl`, in, 2: per-requester address width; 0 = 8-bit, 1 = 16-bit word address.
- `req_rh_wl`, in, 2: per-requester direction; 1 = read, 0 = write.
- `req_addr`, in, 32: requester r's address is `[16r+15:16r]`.
- `req_wdata`, in, 16: requester r's write byte is `[8r+7:8r]`.
- `req_acc`, out, 2: one-cycle pulse; command of requester r captured.
- `rsp_done`, out, 2: one-cycle pulse; response for requester r is valid.
- `rsp_rdata`, out, 8: read byte. Shared, qualified by `rsp_done`.
- `rsp_ack`, out, 1: copy of `i2c_ack`, where 1 = slave NACK. Shared.
- `rsp_timeout`, out, 1: 1 = watchdog expired. Shared.
- `busy`, out, 1: high whenever the state is not IDLE.
- `i2c_exec`, out, 1: start pulse to `i2c_dri`.
- `bit_ctrl`, `i2c_rh_wl`, out, 1 each: latched command fields to `i2c_dri`.
- `i2c_addr`, out, 16: latched command field to `i2c_dri`.
- `i2c_data_w`, out, 8: latched command field to `i2c_dri`.
- `i2c_done`, `i2c_ack`, in, 1 each: completion and NACK status from `i2c_dri`.
- `i2c_data_r`, in, 8: read byte from `i2c_dri`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE → ISSUE when `req != 0`.
  - One request pending: that requester wins.
  - Both pending: the requester not granted last time wins.
  - The `last_gnt` register resets to 1, so requester 0 wins the first tie.
- On the IDLE → ISSUE edge:
  - Latch the winner's `bit_ctrl`, `rh_wl`, `addr`, `wdata` and index `gnt`.
  - Update `last_gnt`.
  - Clear the watchdog counter.
- ISSUE (1 cycle): `i2c_exec` = 1 and `req_acc[gnt]` = 1. Next state is WAIT.
- WAIT:
  - The counter increments each cycle.
  - If `i2c_done` = 1, capture `i2c_data_r` and `i2c_ack`, clear `rsp_timeout`, and go to RESP.
  - Else if counter = `TIMEOUT_CYC`-1: set `rsp_rdata` = 0x00, `rsp_ack` = 1, `rsp_timeout` = 1, and go to RESP.
- RESP (1 cycle): `rsp_done[gnt]` = 1. Go to GAP, or straight to IDLE when `GAP_CYC` = 0.
- GAP: wait `GAP_CYC` cycles, then go to IDLE.
- `i2c_done` is sampled only in WAIT. A late `i2c_done` after a timeout is ignored.
- Requester contract:
  - Hold `req` and all fields stable until `req_acc` is seen.
  - Drop `req` the cycle after `req_acc`, or keep it high to queue another transaction.
  - Fields sampled outside the IDLE→ISSUE edge are don't-care.
- Driver-side outputs hold their latched values from ISSUE through GAP. `rsp_rdata`, `rsp_ack` and `rsp_timeout` hold until the next RESP.
- Timeout arithmetic: 16-bit counter, compared against `TIMEOUT_CYC`-1. The counter never wraps.

## Timing
- Reset values:
  - All outputs 0 and the state is IDLE.
  - `last_gnt` = 1 and the counter = 0.
  - A reset mid-transaction discards it and produces no `rsp_done`.
- Request path: `req[r]` sampled in IDLE at cycle t → `req_acc[r]` and `i2c_exec` high in cycle t+1 → WAIT from t+2.
- Completion: `i2c_done` high in WAIT at cycle d → `rsp_done` high in cycle d+1.
- Timeout: `rsp_done` occurs `TIMEOUT_CYC`+1 cycles after `i2c_exec`.
- Back-to-back throughput: the next ISSUE is at earliest RESP + `GAP_CYC` + 2 cycles.
- Starvation is bounded. With both requests held, grants alternate 0,1,0,1.

## Structure
- Shared package `i2c_arb_pkg` holds:
  - the state encoding constants (IDLE..GAP);
  - `I2C_ADDR_W` = 16 and `I2C_DATA_W` = 8;
  - the default `TIMEOUT_CYC` and `GAP_CYC`.
- Sub-module `i2c_rr_pick`: combinational two-way round-robin picker. Inputs `req[1:0]` and `last_gnt`; outputs `valid` and `gnt`.
- The FSM, command latches, watchdog and response registers live in `i2c_arbiter`.

## Test plan
- Single request: requester 0 read, addr 0x0123, bit_ctrl = 1; driver model returns 0x5A, ack = 0 after 300 cycles.
  - Expect `req_acc[0]` and `i2c_exec` at t+1, with `i2c_addr` = 0x0123 and `i2c_rh_wl` = 1.
  - Expect `rsp_done[0]` one cycle after done, with `rsp_rdata` = 0x5A, `rsp_ack` = 0, `rsp_timeout` = 0.
- Tie: both requesters raise `req` in the same cycle after reset and hold it for 4 transactions. Expect grant order 0,1,0,1 and `req_wdata` forwarded per winner.
- NACK: requester 1 write of 0xA5; model returns done with ack = 1. Expect `rsp_done[1]`, `rsp_ack` = 1, `rsp_timeout` = 0.
- Timeout: `TIMEOUT_CYC` = 50 and the model never asserts done.
  - Expect `rsp_done` exactly 51 cycles after `i2c_exec`, with `rsp_timeout` = 1 and `rsp_rdata` = 0x00.
  - A done injected later is ignored: no extra `rsp_done`.
- Reset mid-WAIT: assert `rst` for 1 cycle while in WAIT.
  - Expect all outputs 0 and no `rsp_done` for the aborted transaction.
  - Expect the next tie to be won by requester 0.
- Gap: `GAP_CYC` = 4 with `req[0]` held. Expect consecutive `i2c_exec` pulses spaced by the driver latency plus 7 cycles (ISSUE→WAIT, RESP, 4 GAP cycles, IDLE).

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared encodings, widths and defaults for the two-client I2C arbiter.
package i2c_arb_pkg;

  localparam int I2C_ADDR_W      = 16;
  localparam int I2C_DATA_W      = 8;
  localparam int TIMEOUT_CYC_DEF = 20000;
  localparam int GAP_CYC_DEF     = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to
// whichever requester was not granted last time.
module i2c_rr_pick (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       valid,
  output logic       gnt
);

  // Winner selection
  always_comb begin
    valid = |req;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_gnt;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one i2c_dri byte engine between two requesters: round-robin grant,
// command latch, single exec pulse, watchdog on i2c_done, response return.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int GAP_CYC     = GAP_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [1:0]              req_bit_ctrl,
  input  logic [1:0]              req_rh_wl,
  input  logic [2*I2C_ADDR_W-1:0] req_addr,
  input  logic [2*I2C_DATA_W-1:0] req_wdata,
  output logic [1:0]              req_acc,
  output logic [1:0]              rsp_done,
  output logic [I2C_DATA_W-1:0]   rsp_rdata,
  output logic                    rsp_ack,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic                    i2c_exec,
  output logic                    bit_ctrl,
  output logic                    i2c_rh_wl,
  output logic [I2C_ADDR_W-1:0]   i2c_addr,
  output logic [I2C_DATA_W-1:0]   i2c_data_w,
  input  logic                    i2c_done,
  input  logic                    i2c_ack,
  input  logic [I2C_DATA_W-1:0]   i2c_data_r
);

  // GAP_LAST is never reached when GAP_CYC is 0 because RESP skips GAP.
  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);

  arb_state_t             state_r;
  arb_state_t             state_nx_s;
  logic                   last_gnt_r;
  logic                   gnt_r;
  logic [15:0]            wd_cnt_r;
  logic [7:0]             gap_cnt_r;
  logic                   pick_valid_s;
  logic                   pick_gnt_s;
  logic                   issue_s;
  logic                   done_hit_s;
  logic                   tmo_hit_s;

  logic [1:0]             req_acc_r;
  logic [1:0]             rsp_done_r;
  logic [I2C_DATA_W-1:0]  rsp_rdata_r;
  logic                   rsp_ack_r;
  logic                   rsp_timeout_r;
  logic                   busy_r;
  logic                   exec_r;
  logic                   bit_ctrl_r;
  logic                   rh_wl_r;
  logic [I2C_ADDR_W-1:0]  addr_r;
  logic [I2C_DATA_W-1:0]  wdata_r;

  i2c_rr_pick u_pick (
    .req      (req),
    .last_gnt (last_gnt_r),
    .valid    (pick_valid_s),
    .gnt      (pick_gnt_s)
  );

  // Next-state decode and per-transition strobes
  always_comb begin
    state_nx_s = state_r;
    issue_s    = 1'b0;
    done_hit_s = 1'b0;
    tmo_hit_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_nx_s = ST_ISSUE;
          issue_s    = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nx_s = ST_WAIT;
      ST_WAIT: begin
        if (i2c_done) begin
          state_nx_s = ST_RESP;
          done_hit_s = 1'b1;
        end else if (wd_cnt_r == WD_LAST) begin
          state_nx_s = ST_RESP;
          tmo_hit_s  = 1'b1;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (GAP_CYC == 32'sd0) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_GAP;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Command latch, watchdog, gap counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_r    <= 1'b1;
      gnt_r         <= 1'b0;
      wd_cnt_r      <= 16'd0;
      gap_cnt_r     <= 8'd0;
      req_acc_r     <= 2'b00;
      rsp_done_r    <= 2'b00;
      rsp_rdata_r   <= 8'h00;
      rsp_ack_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
      busy_r        <= 1'b0;
      exec_r        <= 1'b0;
      bit_ctrl_r    <= 1'b0;
      rh_wl_r       <= 1'b0;
      addr_r        <= 16'h0000;
      wdata_r       <= 8'h00;
    end else begin
      req_acc_r  <= 2'b00;
      rsp_done_r <= 2'b00;
      exec_r     <= issue_s;
      busy_r     <= (state_nx_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (issue_s) begin
            gnt_r                 <= pick_gnt_s;
            last_gnt_r            <= pick_gnt_s;
            wd_cnt_r              <= 16'd0;
            req_acc_r[pick_gnt_s] <= 1'b1;
            bit_ctrl_r            <= req_bit_ctrl[pick_gnt_s];
            rh_wl_r               <= req_rh_wl[pick_gnt_s];
            addr_r  <= pick_gnt_s ? req_addr[I2C_ADDR_W +: I2C_ADDR_W]
                                  : req_addr[0 +: I2C_ADDR_W];
            wdata_r <= pick_gnt_s ? req_wdata[I2C_DATA_W +: I2C_DATA_W]
                                  : req_wdata[0 +: I2C_DATA_W];
          end else begin
            wd_cnt_r <= wd_cnt_r;
          end
        end
        ST_WAIT: begin
          // Saturate rather than wrap; WD_LAST is always below the ceiling.
          if (wd_cnt_r != 16'hFFFF) begin
            wd_cnt_r <= wd_cnt_r + 16'd1;
          end else begin
            wd_cnt_r <= wd_cnt_r;
          end
          if (done_hit_s) begin
            rsp_done_r[gnt_r] <= 1'b1;
            rsp_rdata_r       <= i2c_data_r;
            rsp_ack_r         <= i2c_ack;
            rsp_timeout_r     <= 1'b0;
          end else if (tmo_hit_s) begin
            rsp_done_r[gnt_r] <= 1'b1;
            rsp_rdata_r       <= 8'h00;
            rsp_ack_r         <= 1'b1;
            rsp_timeout_r     <= 1'b1;
          end else begin
            rsp_done_r <= 2'b00;
          end
        end
        ST_RESP: gap_cnt_r <= 8'd0;
        ST_GAP:  gap_cnt_r <= gap_cnt_r + 8'd1;
        default: gap_cnt_r <= gap_cnt_r;
      endcase
    end
  end

  assign req_acc     = req_acc_r;
  assign rsp_done    = rsp_done_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_ack     = rsp_ack_r;
  assign rsp_timeout = rsp_timeout_r;
  assign busy        = busy_r;
  assign i2c_exec    = exec_r;
  assign bit_ctrl    = bit_ctrl_r;
  assign i2c_rh_wl   = rh_wl_r;
  assign i2c_addr    = addr_r;
  assign i2c_data_w  = wdata_r;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed and randomized checks of i2c_arbiter against a transaction-level
// model of grant order, command forwarding and response timing.
module tb_i2c_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req, req_bit_ctrl, req_rh_wl;
  logic [31:0] req_addr;
  logic [15:0] req_wdata;
  logic        i2c_done, i2c_ack, t_done;
  logic [7:0]  i2c_data_r;

  logic [1:0]  req_acc, rsp_done, t_req_acc, t_rsp_done;
  logic [7:0]  rsp_rdata, i2c_data_w, t_rsp_rdata, t_data_w;
  logic        rsp_ack, rsp_timeout, busy, i2c_exec, bit_ctrl, i2c_rh_wl;
  logic        t_rsp_ack, t_rsp_timeout, t_busy, t_exec, t_bit_ctrl, t_rh_wl;
  logic [15:0] i2c_addr, t_addr;

  int   checks = 0;
  int   failures = 0;
  logic model_last;

  i2c_arbiter #(.TIMEOUT_CYC(1000), .GAP_CYC(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_bit_ctrl(req_bit_ctrl),
    .req_rh_wl(req_rh_wl), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_acc(req_acc), .rsp_done(rsp_done), .rsp_rdata(rsp_rdata),
    .rsp_ack(rsp_ack), .rsp_timeout(rsp_timeout), .busy(busy),
    .i2c_exec(i2c_exec), .bit_ctrl(bit_ctrl), .i2c_rh_wl(i2c_rh_wl),
    .i2c_addr(i2c_addr), .i2c_data_w(i2c_data_w), .i2c_done(i2c_done),
    .i2c_ack(i2c_ack), .i2c_data_r(i2c_data_r)
  );

  // Short-watchdog, zero-gap instance whose driver never completes on time.
  i2c_arbiter #(.TIMEOUT_CYC(50), .GAP_CYC(0)) dut_t (
    .clk(clk), .rst(rst), .req(req), .req_bit_ctrl(req_bit_ctrl),
    .req_rh_wl(req_rh_wl), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_acc(t_req_acc), .rsp_done(t_rsp_done), .rsp_rdata(t_rsp_rdata),
    .rsp_ack(t_rsp_ack), .rsp_timeout(t_rsp_timeout), .busy(t_busy),
    .i2c_exec(t_exec), .bit_ctrl(t_bit_ctrl), .i2c_rh_wl(t_rh_wl),
    .i2c_addr(t_addr), .i2c_data_w(t_data_w), .i2c_done(t_done),
    .i2c_ack(1'b0), .i2c_data_r(8'hC3)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs_main();
    return 64'({req_acc, rsp_done, rsp_rdata, rsp_ack, rsp_timeout, busy, i2c_exec,
                bit_ctrl, i2c_rh_wl, i2c_addr, i2c_data_w});
  endfunction

  function automatic logic [63:0] outs_t();
    return 64'({t_req_acc, t_rsp_done, t_rsp_rdata, t_rsp_ack, t_rsp_timeout, t_busy,
                t_exec, t_bit_ctrl, t_rh_wl, t_addr, t_data_w});
  endfunction

  // Round-robin rule: a sole requester wins; a tie goes to the one not granted last.
  function automatic logic model_pick(input logic [1:0] rq, input logic last);
    if (rq == 2'b11) return ~last;
    else return rq[1];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic wait_exec(input string tag);
    int n;
    n = 0;
    tick();
    while (i2c_exec !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_exec_seen"}, 64'(i2c_exec), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_issue(input string tag, input logic r);
    chk({tag, "_acc"},      64'(req_acc),    r ? 64'd2 : 64'd1);
    chk({tag, "_exec"},     64'(i2c_exec),   64'd1);
    chk({tag, "_addr"},     64'(i2c_addr),   64'(r ? req_addr[31:16] : req_addr[15:0]));
    chk({tag, "_data_w"},   64'(i2c_data_w), 64'(r ? req_wdata[15:8] : req_wdata[7:0]));
    chk({tag, "_rh_wl"},    64'(i2c_rh_wl),  64'(req_rh_wl[r]));
    chk({tag, "_bit_ctrl"}, 64'(bit_ctrl),   64'(req_bit_ctrl[r]));
    model_last = r;
  endtask

  // Driver model: completes lat cycles after the exec cycle, then checks the response.
  task automatic serve(input string tag, input int lat, input logic [7:0] d,
                       input logic ak, input logic r);
    int spur;
    spur = 0;
    for (int i = 0; i < lat; i++) begin
      tick();
      if (rsp_done !== 2'b00 || i2c_exec !== 1'b0) spur++;
    end
    i2c_done = 1'b1;
    i2c_data_r = d;
    i2c_ack = ak;
    tick();
    i2c_done = 1'b0;
    chk({tag, "_quiet_wait"},  64'(spur),        64'd0);
    chk({tag, "_rsp_done"},    64'(rsp_done),    r ? 64'd2 : 64'd1);
    chk({tag, "_rsp_rdata"},   64'(rsp_rdata),   64'(d));
    chk({tag, "_rsp_ack"},     64'(rsp_ack),     64'(ak));
    chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'd0);
  endtask

  initial begin
    logic       w;
    int         n, spur, lat;
    logic [7:0] d;
    logic       ak;

    rst = 1'b1; req = 2'b00; req_bit_ctrl = 2'b00; req_rh_wl = 2'b00;
    req_addr = 32'h0; req_wdata = 16'h0; i2c_done = 1'b0; i2c_ack = 1'b0;
    i2c_data_r = 8'h00; t_done = 1'b0; model_last = 1'b1;
    repeat (3) tick();
    chk("reset_outs", outs_main(), 64'd0);
    chk("reset_outs_t", outs_t(), 64'd0);
    rst = 1'b0;
    tick();

    // Single read from requester 0, 16-bit address, 300-cycle driver latency.
    req = 2'b01; req_bit_ctrl = 2'b01; req_rh_wl = 2'b01;
    req_addr = {16'h0000, 16'h0123}; req_wdata = 16'h0000;
    w = model_pick(req, model_last);
    tick();
    chk_issue("single", w);
    req = 2'b00;
    chk("single_busy", 64'(busy), 64'd1);
    serve("single", 300, 8'h5A, 1'b0, w);
    wait_idle("single");

    // Tie held for four transactions: grants must alternate starting with 0.
    do_reset();
    req = 2'b11; req_bit_ctrl = 2'b10; req_rh_wl = 2'b00;
    req_addr = {16'hBEEF, 16'h0042}; req_wdata = {8'h3C, 8'hC3};
    for (int k = 0; k < 4; k++) begin
      w = model_pick(req, model_last);
      wait_exec("tie");
      chk("tie_order", 64'(req_acc), (k % 2 == 1) ? 64'd2 : 64'd1);
      chk_issue("tie", w);
      if (k == 3) req = 2'b00;
      serve("tie", 5 + k, 8'(k + 16), 1'b0, w);
    end
    wait_idle("tie");

    // Requester 1 write answered with NACK.
    req = 2'b10; req_rh_wl = 2'b00; req_wdata = {8'hA5, 8'h00};
    req_addr = {16'h0077, 16'h0000};
    w = model_pick(req, model_last);
    wait_exec("nack");
    chk_issue("nack", w);
    req = 2'b00;
    serve("nack", 20, 8'h99, 1'b1, w);
    wait_idle("nack");

    // Reset while waiting on the driver: outputs clear, no response, tie back to 0.
    req = 2'b01;
    w = model_pick(req, model_last);
    wait_exec("rstw");
    chk_issue("rstw", w);
    req = 2'b00;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("rstw_outs", outs_main(), 64'd0);
    rst = 1'b0;
    model_last = 1'b1;
    i2c_done = 1'b1; i2c_data_r = 8'hEE;
    spur = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_done !== 2'b00) spur++;
    end
    i2c_done = 1'b0;
    chk("rstw_no_rsp", 64'(spur), 64'd0);
    req = 2'b11; req_wdata = {8'h12, 8'h34};
    w = model_pick(req, model_last);
    wait_exec("rstw_tie");
    chk("rstw_tie_winner", 64'(req_acc), 64'd1);
    chk_issue("rstw_tie", w);
    req = 2'b00;
    serve("rstw_tie", 4, 8'h21, 1'b0, w);
    wait_idle("rstw_tie");

    // Back-to-back with req[0] held: exec spacing = latency + 7.
    req = 2'b01; req_wdata = {8'h00, 8'h6B};
    w = model_pick(req, model_last);
    wait_exec("gap");
    chk_issue("gap", w);
    serve("gap", 10, 8'h11, 1'b0, w);
    n = 0;
    while (i2c_exec !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("gap_spacing", 64'(10 + 1 + n), 64'(10 + 7));
    w = model_pick(req, model_last);
    chk_issue("gap2", w);
    req = 2'b00;
    serve("gap2", 3, 8'h22, 1'b1, w);
    wait_idle("gap2");

    // Randomized requests, fields, latency and status.
    for (int k = 0; k < 24; k++) begin
      req_bit_ctrl = 2'($urandom);
      req_rh_wl    = 2'($urandom);
      req_addr     = $urandom;
      req_wdata    = 16'($urandom);
      lat = int'($urandom_range(40, 1));
      d   = 8'($urandom);
      ak  = 1'($urandom);
      req = 2'($urandom_range(3, 1));
      w = model_pick(req, model_last);
      wait_exec("rnd");
      chk_issue("rnd", w);
      req = 2'b00;
      serve("rnd", lat, d, ak, w);
      wait_idle("rnd");
    end

    // Watchdog on the 50-cycle instance; a late done must be ignored.
    do_reset();
    req = 2'b01; req_rh_wl = 2'b01; req_addr = {16'h0000, 16'h0456};
    tick();
    chk("tmo_exec", 64'(t_exec), 64'd1);
    req = 2'b00;
    n = 0;
    while (t_rsp_done === 2'b00 && n < 200) begin
      tick();
      n++;
    end
    chk("tmo_latency", 64'(n), 64'd51);
    chk("tmo_rsp_done", 64'(t_rsp_done), 64'd1);
    chk("tmo_flag", 64'(t_rsp_timeout), 64'd1);
    chk("tmo_rdata", 64'(t_rsp_rdata), 64'h00);
    chk("tmo_ack", 64'(t_rsp_ack), 64'd1);
    tick();
    chk("tmo_gap0_idle", 64'(t_busy), 64'd0);
    t_done = 1'b1;
    spur = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (t_rsp_done !== 2'b00) spur++;
    end
    t_done = 1'b0;
    chk("tmo_late_done", 64'(spur), 64'd0);
    chk("tmo_hold_flag", 64'(t_rsp_timeout), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
